// File: rtl/piano_tiles_pkg.sv
// rtl/piano_tiles_pkg.sv - shared widths, arbiter/column state encodings and index helper
package piano_tiles_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 3;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Column engine states live here so each requester picks its own color.
    typedef enum logic [1:0] {
        COL_IDLE = 2'd0,
        COL_FALL = 2'd1,
        COL_HIT  = 2'd2,
        COL_MISS = 2'd3
    } col_state_t;

    localparam logic [COLOR_W-1:0] COLOR_BG   = 3'b000;
    localparam logic [COLOR_W-1:0] COLOR_TILE = 3'b111;
    localparam logic [COLOR_W-1:0] COLOR_HIT  = 3'b010;
    localparam logic [COLOR_W-1:0] COLOR_MISS = 3'b100;

    // Wrap by explicit compare so non-power-of-2 requester counts work.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder starting at i_ptr
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [2:0]   o_idx,
    output logic         o_valid
);

    int w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!o_valid && (j == w_cand) && i_req[j]) begin
                    o_valid  = 1'b1;
                    o_gnt[j] = 1'b1;
                    o_idx    = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - round-robin vga pixel-write arbiter with locked bursts
// Optional starvation watchdog and o_starve_flag port enabled by PIXEL_ARB_WATCHDOG_EN.
module pixel_write_arbiter
    import piano_tiles_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 160,
    parameter int STARVE_LIMIT = 512
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ-1:0]         i_req_lock,
    input  logic [NUM_REQ*X_W-1:0]     i_req_x,
    input  logic [NUM_REQ*Y_W-1:0]     i_req_y,
    input  logic [NUM_REQ*COLOR_W-1:0] i_req_color,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [2:0]                 o_owner,
    output logic [X_W-1:0]             o_vga_x,
    output logic [Y_W-1:0]             o_vga_y,
    output logic [COLOR_W-1:0]         o_vga_color,
`ifdef PIXEL_ARB_WATCHDOG_EN
    output logic                       o_starve_flag,
`endif
    output logic                       o_vga_write
);

    localparam int BC_W = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || STARVE_LIMIT < 1) begin : g_param_check
        $error("pixel_write_arbiter: parameter out of range");
    end

    arb_state_t            r_state;
    logic [2:0]            r_rr_ptr;
    logic [2:0]            r_owner;
    logic [BC_W-1:0]       r_beat_cnt;
    logic [X_W-1:0]        r_vga_x;
    logic [Y_W-1:0]        r_vga_y;
    logic [COLOR_W-1:0]    r_vga_color;
    logic                  r_vga_write;

    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [2:0]            w_pick_idx;
    logic                  w_pick_valid;
    logic [NUM_REQ-1:0]    w_own_oh;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [2:0]            w_idx;
    logic                  w_any;
    logic                  w_lock_sel;
    logic                  w_own_lock;
    logic [X_W-1:0]        w_sel_x;
    logic [Y_W-1:0]        w_sel_y;
    logic [COLOR_W-1:0]    w_sel_color;
    logic                  w_starve_any;
    logic [NUM_REQ-1:0]    w_starve_gnt;
    logic [2:0]            w_starve_idx;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

`ifdef PIXEL_ARB_WATCHDOG_EN
    logic [9:0]         r_wait [NUM_REQ];
    logic [NUM_REQ-1:0] w_starve;
    logic               r_starve_flag;

    always_comb begin
        w_starve     = '0;
        w_starve_gnt = '0;
        w_starve_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_starve[j] = i_req[j] && (int'(r_wait[j]) >= STARVE_LIMIT);
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_starve[j]) begin
                w_starve_gnt    = '0;
                w_starve_gnt[j] = 1'b1;
                w_starve_idx    = 3'(j);
            end
        end
        w_starve_any = |w_starve;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                r_wait[j] <= '0;
            end
            r_starve_flag <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!i_req[j] || w_gnt[j]) begin
                    r_wait[j] <= '0;
                end else if (r_wait[j] != '1) begin
                    r_wait[j] <= r_wait[j] + 1'b1;
                end
            end
            if (w_starve_any) begin
                r_starve_flag <= 1'b1;
            end
        end
    end

    assign o_starve_flag = r_starve_flag;
`else
    assign w_starve_any = 1'b0;
    assign w_starve_gnt = '0;
    assign w_starve_idx = '0;
`endif

    always_comb begin
        w_own_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_own_oh[j] = (r_owner == 3'(j));
        end
    end

    // Grant is combinational but forced off while reset is held.
    always_comb begin
        w_gnt = '0;
        w_idx = r_owner;
        if (r_state == BURST) begin
            w_gnt = i_req & w_own_oh;
        end else if (w_starve_any) begin
            w_gnt = w_starve_gnt;
            w_idx = w_starve_idx;
        end else if (w_pick_valid) begin
            w_gnt = w_pick_gnt;
            w_idx = w_pick_idx;
        end
        if (!i_resetn) begin
            w_gnt = '0;
        end
    end

    assign w_any      = |w_gnt;
    assign w_lock_sel = |(i_req_lock & w_gnt);
    assign w_own_lock = |(i_req_lock & w_own_oh);

    always_comb begin
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_sel_color = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt[j]) begin
                w_sel_x     = i_req_x[j*X_W +: X_W];
                w_sel_y     = i_req_y[j*Y_W +: Y_W];
                w_sel_color = i_req_color[j*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= ARB;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_beat_cnt  <= '0;
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_vga_color <= '0;
            r_vga_write <= 1'b0;
        end else begin
            r_vga_write <= w_any;
            if (w_any) begin
                r_vga_x     <= w_sel_x;
                r_vga_y     <= w_sel_y;
                r_vga_color <= w_sel_color;
            end
            case (r_state)
                ARB: begin
                    if (w_any) begin
                        r_owner  <= w_idx;
                        r_rr_ptr <= rr_next(w_idx, NUM_REQ);
                        if (w_lock_sel && MAX_BURST > 1) begin
                            r_state    <= BURST;
                            r_beat_cnt <= BC_W'(1);
                        end
                    end
                end
                BURST: begin
                    if (!w_any) begin
                        r_state <= ARB;
                    end else begin
                        if (int'(r_beat_cnt) < MAX_BURST) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                        if (!w_own_lock || (int'(r_beat_cnt) + 1 == MAX_BURST) || w_starve_any) begin
                            r_state <= ARB;
                        end
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign o_gnt       = w_gnt;
    assign o_owner     = r_owner;
    assign o_vga_x     = r_vga_x;
    assign o_vga_y     = r_vga_y;
    assign o_vga_color = r_vga_color;
    assign o_vga_write = r_vga_write;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - directed self-checking bench for pixel_write_arbiter
module tb_pixel_write_arbiter;
    import piano_tiles_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [39:0] rx;
    logic [35:0] ry;
    logic [11:0] rc;
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic [9:0]  vx;
    logic [8:0]  vy;
    logic [2:0]  vc;
    logic        vw;
`ifdef PIXEL_ARB_WATCHDOG_EN
    logic        starve;
`endif

    int errors = 0;
    int checks = 0;
    int xs[4];
    int served0;
    int exp_g;

    always #5 clk = ~clk;

    pixel_write_arbiter #(
        .NUM_REQ      (4),
        .MAX_BURST    (160),
        .STARVE_LIMIT (8)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_req         (req),
        .i_req_lock    (lock),
        .i_req_x       (rx),
        .i_req_y       (ry),
        .i_req_color   (rc),
        .o_gnt         (gnt),
        .o_owner       (owner),
        .o_vga_x       (vx),
        .o_vga_y       (vy),
        .o_vga_color   (vc),
`ifdef PIXEL_ARB_WATCHDOG_EN
        .o_starve_flag (starve),
`endif
        .o_vga_write   (vw)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input int i, input int x, input int y, input int c);
        rx[i*10 +: 10] = 10'(x);
        ry[i*9 +: 9]   = 9'(y);
        rc[i*3 +: 3]   = 3'(c);
    endtask

    task automatic to_neg;
        @(negedge clk);
    endtask

    task automatic to_drive;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish");
        $fatal(1);
    end

    initial begin
        xs[0] = 0; xs[1] = 161; xs[2] = 321; xs[3] = 481;
        resetn = 1'b0;
        req    = 4'b1111;
        lock   = 4'b0000;
        rx = '0; ry = '0; rc = '0;
        for (int i = 0; i < 4; i++) pix(i, xs[i], 10 + i, i + 1);

        // reset state with requests already pending
        to_neg;
        to_neg;
        chk("rst_gnt", gnt, 0);
        chk("rst_vw", vw, 0);
        chk("rst_owner", owner, 0);
        chk("rst_vx", vx, 0);

        // all four request one pixel each
        to_drive;
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            to_neg;
            chk("t1_gnt", gnt, 1 << k);
            if (k > 0) begin
                chk("t1_vx", vx, xs[k-1]);
                chk("t1_vy", vy, 10 + k - 1);
                chk("t1_vc", vc, k);
                chk("t1_vw", vw, 1);
                chk("t1_owner", owner, k - 1);
            end
            to_drive;
            req[k] = 1'b0;
        end
        to_neg;
        chk("t1_gnt_idle", gnt, 0);
        chk("t1_vx_last", vx, 481);
        chk("t1_vw_last", vw, 1);
        chk("t1_owner_last", owner, 3);
        to_drive;
        to_neg;
        chk("t1_vw_bubble", vw, 0);

        // single continuous requester
        to_drive;
        req = 4'b0100;
        pix(2, 100, 50, 5);
        for (int n = 0; n < 6; n++) begin
            to_neg;
            chk("t2_gnt", gnt, 4);
            if (n > 0) begin
                chk("t2_vx", vx, 100 + n - 1);
                chk("t2_vw", vw, 1);
                chk("t2_owner", owner, 2);
            end
            to_drive;
            pix(2, 100 + n + 1, 50, 5);
        end
        req = 4'b0000;
        to_neg;
        chk("t2_vx_last", vx, 105);
        chk("t2_gnt_idle", gnt, 0);

        // one grant to requester 3 moves the pointer back to 0
        to_drive;
        req = 4'b1000;
        pix(3, 7, 7, 7);
        to_neg;
        chk("align_gnt", gnt, 8);
        to_drive;
        req = 4'b0000;

`ifndef PIXEL_ARB_WATCHDOG_EN
        // locked burst truncated at MAX_BURST
        req  = 4'b1111;
        lock = 4'b0001;
        served0 = 0;
        pix(0, 0, 1, 1);
        for (int i = 1; i < 4; i++) pix(i, 200 + i, 2, 2);
        for (int c = 0; c < 164; c++) begin
            exp_g = (c < 160) ? 1 : (c == 160) ? 2 : (c == 161) ? 4 : (c == 162) ? 8 : 1;
            to_neg;
            chk("t3_gnt", gnt, exp_g);
            if (c == 160) begin
                chk("t3_vx_b160", vx, 159);
                chk("t3_owner_b160", owner, 0);
            end
            if (c == 163) begin
                chk("t3_vx_r3", vx, 203);
                chk("t3_owner_r3", owner, 3);
            end
            to_drive;
            if (exp_g == 1) begin
                served0++;
                pix(0, served0, 1, 1);
                if (served0 == 161) begin
                    req[0]  = 1'b0;
                    lock[0] = 1'b0;
                end
            end else begin
                for (int i = 1; i < 4; i++) if (exp_g == (1 << i)) req[i] = 1'b0;
            end
        end
        to_neg;
        chk("t3_gnt_idle", gnt, 0);
        chk("t3_vx_last", vx, 160);
        chk("t3_owner_last", owner, 0);

        // burst owner withdraws its request after beat 10
        to_drive;
        req  = 4'b0110;
        lock = 4'b0010;
        pix(1, 300, 3, 3);
        pix(2, 400, 4, 4);
        for (int c = 0; c < 10; c++) begin
            to_neg;
            chk("t4_gnt", gnt, 2);
            to_drive;
            pix(1, 301 + c, 3, 3);
            if (c == 9) req[1] = 1'b0;
        end
        to_neg;
        chk("t4_gnt_drop", gnt, 0);
        chk("t4_vw_b10", vw, 1);
        chk("t4_vx_b10", vx, 309);
        to_drive;
        to_neg;
        chk("t4_vw_bubble", vw, 0);
        chk("t4_gnt_next", gnt, 4);
        to_drive;
        req  = 4'b0000;
        lock = 4'b0000;
        to_neg;
        chk("t4_vx_next", vx, 400);
        chk("t4_owner_next", owner, 2);
        to_drive;
`endif

        // asynchronous reset in the middle of a burst
        req  = 4'b0010;
        lock = 4'b0010;
        pix(1, 500, 5, 5);
        for (int c = 0; c < 4; c++) begin
            to_neg;
            chk("t5_gnt", gnt, 2);
            to_drive;
            pix(1, 501 + c, 5, 5);
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_rst_vw", vw, 0);
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_owner", owner, 0);
        chk("t5_rst_vx", vx, 0);
        to_drive;
        to_neg;
        resetn = 1'b1;
        req  = 4'b0011;
        lock = 4'b0000;
        pix(0, 11, 1, 1);
        #1;
        chk("t5_restart_gnt", gnt, 1);
        to_drive;
        to_neg;
        chk("t5_restart_vw", vw, 1);
        chk("t5_restart_vx", vx, 11);
        chk("t5_next_gnt", gnt, 2);
        to_drive;
        req = 4'b0000;

`ifdef PIXEL_ARB_WATCHDOG_EN
        // starving requester 3 truncates requester 0's burst
        resetn = 1'b0;
        to_drive;
        resetn = 1'b1;
        to_neg;
        chk("t6_flag_init", starve, 0);
        to_drive;
        req  = 4'b1001;
        lock = 4'b0001;
        pix(0, 0, 1, 1);
        pix(3, 600, 6, 6);
        for (int c = 0; c < 9; c++) begin
            to_neg;
            chk("t6_gnt", gnt, 1);
            to_drive;
            pix(0, c + 1, 1, 1);
        end
        to_neg;
        chk("t6_gnt_starved", gnt, 8);
        chk("t6_flag", starve, 1);
        to_drive;
        req  = 4'b0000;
        lock = 4'b0000;
        to_neg;
        chk("t6_vx", vx, 600);
        chk("t6_owner", owner, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
- Shares the single vga_adapter pixel-write port among NUM_REQ drawing engines (one per tile column plus score/overlay drawers).
- Replaces the fixed free-running turn counter with a request/grant handshake, so idle requesters consume no write slots.
- Round-robin arbitration with optional locked bursts, so a requester can finish a row span without interleaving.
- Sits between the column engines and vga_adapter; its outputs drive vga_adapter x/y/color/write directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 160, maximum consecutive grants to one requester while locked (1 disables locking).
- STARVE_LIMIT, 512, wait-cycle threshold for the watchdog (used only with the optional feature).

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request.
- req_lock  in  NUM_REQ  request to keep the grant after the current beat.
- req_x  in  NUM_REQ*10  flattened pixel X, requester i at bits [10i+9:10i].
- req_y  in  NUM_REQ*9  flattened pixel Y.
- req_color  in  NUM_REQ*3  flattened 3-bit color.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- owner  out  3  index of the current or last granted requester (registered).
- vga_x  out  10  registered pixel X to vga_adapter.
- vga_y  out  9  registered pixel Y.
- vga_color  out  3  registered color.
- vga_write  out  1  registered write strobe.

Behaviour:
- Reset (asynchronous, resetn=0): state=ARB, rr_ptr=0, beat_cnt=0, owner=0, vga_x/vga_y/vga_color=0, vga_write=0. gnt=0 while in reset.
- Handshake:
  - A requester holds req=1 with x/y/color stable until it sees gnt[i]=1 at a clock edge.
  - That edge consumes the beat; the requester may present the next pixel in the following cycle.
  - Dropping req without a grant is legal (request withdrawn).
- Latency: data granted in cycle k appears on vga_* with vga_write=1 in cycle k+1. Throughput is 1 pixel/clk. vga_write=0 in any cycle following a no-grant cycle.
- ARB state:
  - Grant the first asserted req scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On a grant to i: owner<=i, rr_ptr<=(i+1) mod NUM_REQ.
  - If req_lock[i]=1 and MAX_BURST>1: go to BURST with beat_cnt<=1.
  - No req: gnt=0, state holds.
- BURST state:
  - gnt[owner]=req[owner]; all other grants are 0.
  - On a granted beat: beat_cnt++.
  - Exit to ARB after the beat when req_lock[owner]=0 or beat_cnt+1==MAX_BURST (truncation).
  - If req[owner]=0: no grant this cycle, go to ARB; the next requester can be granted the following cycle (one bubble).
  - rr_ptr stays at owner+1, so the burst owner has the lowest priority afterwards.
- Simultaneous events: lock asserted on a requester not currently granted is ignored until it wins in ARB. A single requester with continuous req and lock=0 is granted every cycle.
- Widths: rr_ptr and owner are 3 bits; wrap uses explicit compare to NUM_REQ-1, not a power-of-2 assumption. beat_cnt is clog2(MAX_BURST+1) bits and saturates, never wraps.
- Mid-operation reset: any burst is abandoned; the pending beat is not written.

Optional Feature:
- Macro: PIXEL_ARB_WATCHDOG_EN.
- With the macro:
  - Per-requester wait counters (10 bits, saturating) count cycles with req=1 and gnt=0; cleared on grant or when req drops.
  - If any counter reaches STARVE_LIMIT while in BURST, the burst ends after the current beat regardless of lock.
  - The starving requester with the lowest index is granted next, overriding rr_ptr for one decision.
  - Sticky output starve_flag (extra port, 1 bit, reset 0) is set and cleared only by reset.
- Without the macro: no counters, no starve_flag port; bursts end only on lock drop or MAX_BURST.

Decomposition:
- Package piano_tiles_pkg:
  - Widths: X_W=10, Y_W=9, COLOR_W=3.
  - Arbiter state encoding: ARB=1'b0, BURST=1'b1.
  - Existing column state encodings, shared so color selection moves to the requesters.
- Sub-module rr_pick: combinational round-robin priority encoder (req vector, rr_ptr -> one-hot grant, index, valid), instantiated once.

Test Plan:
- Reset, then req=4'b1111 all lock=0, one pixel each (x=0,161,321,481) -> gnts in order 0,1,2,3, one per cycle. vga_x follows one cycle later as 0,161,321,481 with vga_write=1.
- req only on requester 2, continuous, lock=0 -> gnt[2]=1 every cycle; vga_write stays 1; owner=2.
- Requester 0 lock=1 for 161 pixels with MAX_BURST=160, others requesting -> 160 consecutive gnt[0]. Then gnt[1] next; requester 0 gets the remaining pixel after 1,2,3.
- In BURST, owner drops req at beat 10 -> no grant that cycle, vga_write=0 next cycle. Next requester granted the following cycle.
- resetn pulsed low mid-burst (asynchronous, between edges) -> vga_write=0 and gnt=0 immediately. After release, arbitration restarts at requester 0.
- With PIXEL_ARB_WATCHDOG_EN, STARVE_LIMIT=8, MAX_BURST=160, requester 0 locked and requester 3 waiting -> burst truncated after beat 9. gnt[3] is next; starve_flag=1.
